// File: rtl/dot4_accum.sv
// Streaming dot-product engine: accepts 4-bit operand pairs, multiplies them with a
// 4x4 unsigned array multiplier and emits the wrapped sum of every VEC_LEN products.

module array4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0][7:0] pp;

    // One shifted partial-product row per multiplier bit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign pp[gi] = {4'd0, a & {4{b[gi]}}} << gi;
        end
    endgenerate

    always_comb begin
        p = pp[0] + pp[1] + pp[2] + pp[3];
    end
endmodule

module dot4_accum #(
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);
    localparam int CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       a1_q, a1_d, b1_q, b1_d;
    logic             v1_q, v1_d, last1_q, last1_d;
    logic [7:0]       p2_q, p2_d;
    logic             v2_q, v2_d, last2_q, last2_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [7:0]       prod;
    logic             in_fire;

    array4 u_mul (
        .a (a1_q),
        .b (b1_q),
        .p (prod)
    );

    assign in_ready  = (state_q == ST_ACCUM);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        last1_d     = last1_q;
        v1_d        = in_fire;
        v2_d        = v1_q;
        last2_d     = last1_q;
        p2_d        = v1_q ? prod : p2_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (in_fire) begin
            a1_d    = in_a;
            b1_d    = in_b;
            last1_d = (count_q == LAST_IDX);
        end

        case (state_q)
            ST_ACCUM: begin
                if (in_fire) begin
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (v2_q && last2_q) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_valid_q && out_ready) begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        // The final product bypasses the accumulator straight into the result register.
        if (v2_q) begin
            if (last2_q) begin
                out_data_d  = acc_q + ACC_W'(p2_q);
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = acc_q + ACC_W'(p2_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            count_q     <= '0;
            a1_q        <= '0;
            b1_q        <= '0;
            last1_q     <= 1'b0;
            v1_q        <= 1'b0;
            p2_q        <= '0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            last1_q     <= last1_d;
            v1_q        <= v1_d;
            p2_q        <= p2_d;
            v2_q        <= v2_d;
            last2_q     <= last2_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_dot4_accum.sv
// Randomized bench for dot4_accum: a 16-bit and a 10-bit instance share stimulus and
// are compared against sums computed directly from the operand pairs sent.

module tb_dot4_accum;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_ready;

    logic        in_ready,   out_valid;
    logic [15:0] out_data;
    logic        in_ready10, out_valid10;
    logic [9:0]  out_data10;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dot4_accum #(.VEC_LEN(8), .ACC_W(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    dot4_accum #(.VEC_LEN(8), .ACC_W(10)) u_dut10 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready10),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid10),
        .out_ready (out_ready),
        .out_data  (out_data10)
    );

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // Operand pattern for element i: 0=(15,15) 1=(i,7-i) 2=random 3=(1,1)
    function automatic void pick(input int mode, input int i, output int a, output int b);
        case (mode)
            0:       begin a = 15; b = 15; end
            1:       begin a = i;  b = 7 - i; end
            3:       begin a = 1;  b = 1; end
            default: begin a = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 15)); end
        endcase
    endfunction

    // Drives one full vector, waits for the result and retires it after `hold` stalled cycles.
    task automatic run_vector(input string name, input int mode, input int bubble_max,
                              input int hold);
        longint exp_sum = 0;
        int     a, b, lat;
        logic [15:0] held;
        out_ready = (hold == 0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, bubble_max)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            pick(mode, i, a, b);
            exp_sum += longint'(a * b);
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 4'(a);
            in_b     = 4'(b);
            check_val({name, "_rdy_accept"}, in_ready, 1);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (!out_valid) check_val({name, "_rdy_drain"}, in_ready, 0);
            // Ignored traffic while the vector drains.
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 4'($urandom_range(0, 15));
            in_b     = 4'($urandom_range(0, 15));
        end
        if (!out_valid) begin
            check_val({name, "_lat_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        $display("%s: sum=%0d expected=%0d latency=%0d hold=%0d", name, out_data,
                 exp_sum % 65536, lat, hold);
        check_val({name, "_latency"}, lat, 3);
        check_val({name, "_data16"}, out_data, exp_sum % 65536);
        check_val({name, "_valid10"}, out_valid10, 1);
        check_val({name, "_data10"}, out_data10, exp_sum % 1024);
        check_val({name, "_rdy_out"}, in_ready, 0);
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 4'($urandom_range(0, 15));
            in_b     = 4'($urandom_range(0, 15));
            check_val({name, "_hold_valid"}, out_valid, 1);
            check_val({name, "_hold_data"}, out_data, held);
            check_val({name, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_val({name, "_valid_drop"}, out_valid, 0);
        check_val({name, "_rdy_return"}, in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        do_reset(2);
        $display("reset: in_ready=%0d out_valid=%0d out_data=%0d", in_ready, out_valid, out_data);
        check_val("reset_rdy", in_ready, 1);
        check_val("reset_valid", out_valid, 0);
        check_val("reset_data", out_data, 0);
        check_val("reset_data10", out_data10, 0);

        run_vector("max_pairs", 0, 0, 0);
        run_vector("ramp_bubbles", 1, 3, 0);
        run_vector("ramp_backpressure", 1, 1, 10);
        run_vector("after_hold", 2, 0, 0);

        // Abandon a vector after 5 accepts; nothing of it may leak out.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 4'($urandom_range(1, 15));
            in_b     = 4'($urandom_range(1, 15));
        end
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            check_val("rst_mid_no_valid", out_valid, 0);
            check_val("rst_mid_rdy", in_ready, 1);
            @(negedge clk);
        end
        run_vector("ones_after_rst", 3, 0, 0);

        for (int v = 0; v < 15; v++) begin
            run_vector($sformatf("rand%0d", v), 2, 2, int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
